// File: rtl/instruction_ram_loader.sv
// rtl/instruction_ram_loader.sv - byte-stream image loader writing instruction RAM; LOADER_CHECKSUM_EN adds trailing XOR byte check
module instruction_ram_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32,
    parameter int MAX_WORDS  = 146
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  wrEnable,
    output logic [ADDR_WIDTH-1:0] wrAddress,
    output logic [WORD_WIDTH-1:0] wrData,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic                  loadError,
    output logic [ADDR_WIDTH-1:0] wordsWritten
);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t                state;
    logic [9:0]            count;
    logic [1:0]            byte_idx;
    logic [WORD_WIDTH-9:0] shift;
    logic                  accept;
    logic [9:0]            hdr_count;

    assign accept    = byteValid && byteReady;
    assign hdr_count = {count[9:8], byteIn};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xor_acc <= 8'h00;
        end else if (start && (state == IDLE || state == DONE || state == ERROR)) begin
            xor_acc <= 8'h00;
        end else if (accept && state != CHECK) begin
            xor_acc <= xor_acc ^ byteIn;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            byteReady    <= 1'b0;
            wrEnable     <= 1'b0;
            wrAddress    <= '0;
            wrData       <= '0;
            cpuHold      <= 1'b1;
            loadDone     <= 1'b0;
            loadError    <= 1'b0;
            wordsWritten <= '0;
            count        <= '0;
            byte_idx     <= '0;
            shift        <= '0;
        end else begin
            wrEnable <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state        <= HDR_HI;
                        byteReady    <= 1'b1;
                        wordsWritten <= '0;
                        wrAddress    <= '0;
                        loadDone     <= 1'b0;
                        loadError    <= 1'b0;
                        cpuHold      <= 1'b1;
                        byte_idx     <= '0;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        count <= {byteIn[1:0], 8'h00};
                        if (byteIn[7:2] != 6'd0) begin
                            state     <= ERROR;
                            byteReady <= 1'b0;
                            loadError <= 1'b1;
                        end else begin
                            state <= HDR_LO;
                        end
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        count <= hdr_count;
                        if (hdr_count == 10'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state     <= DONE;
                            byteReady <= 1'b0;
                            loadDone  <= 1'b1;
                            cpuHold   <= 1'b0;
`endif
                        end else if (hdr_count > 10'(MAX_WORDS)) begin
                            state     <= ERROR;
                            byteReady <= 1'b0;
                            loadError <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        shift    <= {shift[WORD_WIDTH-17:0], byteIn};
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth byte completes the word; strobe it next cycle and stall the link
                        if (byte_idx == 2'd3) begin
                            state     <= WRITE;
                            byteReady <= 1'b0;
                            wrEnable  <= 1'b1;
                            wrAddress <= wordsWritten;
                            wrData    <= {shift, byteIn};
                        end
                    end
                end
                WRITE: begin
                    wordsWritten <= wordsWritten + ADDR_WIDTH'(1);
                    if (wordsWritten + ADDR_WIDTH'(1) == ADDR_WIDTH'(count)) begin
`ifdef LOADER_CHECKSUM_EN
                        state     <= CHECK;
                        byteReady <= 1'b1;
`else
                        state    <= DONE;
                        loadDone <= 1'b1;
                        cpuHold  <= 1'b0;
`endif
                    end else begin
                        state     <= DATA;
                        byteReady <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        byteReady <= 1'b0;
                        if (byteIn == xor_acc) begin
                            state    <= DONE;
                            loadDone <= 1'b1;
                            cpuHold  <= 1'b0;
                        end else begin
                            state     <= ERROR;
                            loadError <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    byteReady <= 1'b0;
                end
            endcase
        end
    end

endmodule
